// File: rtl/dcs_pacer_pkg.sv
// Shared DCS definitions for the display command path: 9-bit {dc,byte} opcode
// codes, the settle-delay classes and the classifier used by the pacer.
package dcs_pacer_pkg;

    localparam logic [8:0] DCS_NOP     = 9'h000;
    localparam logic [8:0] DCS_SWRESET = 9'h001;
    localparam logic [8:0] DCS_SLPIN   = 9'h010;
    localparam logic [8:0] DCS_SLPOUT  = 9'h011;
    localparam logic [8:0] DCS_DISPOFF = 9'h028;
    localparam logic [8:0] DCS_DISPON  = 9'h029;
    localparam logic [8:0] DCS_CASET   = 9'h02A;
    localparam logic [8:0] DCS_RASET   = 9'h02B;
    localparam logic [8:0] DCS_RAMWR   = 9'h02C;
    localparam logic [8:0] DCS_MADCTL  = 9'h036;
    localparam logic [8:0] DCS_COLMOD  = 9'h03A;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_RST  = 2'd1,
        CLS_SLP  = 2'd2
    } dcs_class_e;

    // Parameter words (dc=1) never match because dc is part of the code.
    function automatic dcs_class_e dcs_classify(input logic [8:0] word);
        case (word)
            DCS_SWRESET:           return CLS_RST;
            DCS_SLPIN, DCS_SLPOUT: return CLS_SLP;
            default:               return CLS_NONE;
        endcase
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dcs_pacer_if.sv
// Word/pop handshake between command FIFO, pacer and serialiser.
// A word moves on a clock edge where the consumer pops (get) while its source is not empty.
interface dcs_pacer_if #(
    parameter int W = 8
);
    logic         dc_i;
    logic [W-1:0] in;
    logic         get_i;
    logic         empty_i;
    logic         dc_o;
    logic [W-1:0] out;
    logic         get_o;
    logic         empty_o;

    modport master (
        output dc_i, in, empty_i, get_o,
        input  get_i, dc_o, out, empty_o
    );

    modport slave (
        input  dc_i, in, empty_i, get_o,
        output get_i, dc_o, out, empty_o
    );
endinterface

// File: rtl/dcs_pacer_ms_delay.sv
// Millisecond settle timer: a TICK-cycle prescaler feeding a ms down-counter,
// so no FREQ*ms product is ever needed.
module ms_delay #(
    parameter int TICK = 25_000,
    parameter int MW   = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [MW-1:0] value,
    input  logic          clear,
    input  logic [MW-1:0] init,
    output logic          pause
);
    localparam int PW = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK - 1);

    logic [MW-1:0] ms_q, ms_d;
    logic [PW-1:0] pre_q, pre_d;

    always_comb begin
        ms_d  = ms_q;
        pre_d = pre_q;
        if (clear) begin
            ms_d  = '0;
            pre_d = '0;
        end else if (load) begin
            ms_d  = value;
            pre_d = PRE_MAX;
        end else if (ms_q != '0) begin
            if (pre_q == '0) begin
                pre_d = PRE_MAX;
                ms_d  = ms_q - MW'(1);
            end else begin
                pre_d = pre_q - PW'(1);
            end
        end
    end

    // init is the power-on hold; it is tied to a constant by the parent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ms_q  <= init;
            pre_q <= PRE_MAX;
        end else begin
            ms_q  <= ms_d;
            pre_q <= pre_d;
        end
    end

    assign pause = (ms_q != '0) & ~clear;
endmodule

// File: rtl/dcs_pacer.sv
// DCS command pacer: one-word prefetch buffer that stalls the serialiser for
// a per-command settle time after SWRESET/SLPIN/SLPOUT leave it, plus a power-on hold.
module dcs_pacer
    import dcs_pacer_pkg::*;
#(
    parameter int W     = 8,
    parameter int FREQ  = 25_000_000,
    parameter int T_RST = 5,
    parameter int T_SLP = 120,
    parameter int T_POR = 120
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         bypass,
    dcs_pacer_if.slave   bus,
    output logic         busy
);
    localparam int TICK  = FREQ / 1000;
    localparam int T_MAX = max3(T_RST, T_SLP, T_POR);
    localparam int MW    = (T_MAX > 0) ? $clog2(T_MAX + 1) : 1;

    logic         valid_q, valid_d;
    logic         dc_q, dc_d;
    logic [W-1:0] data_q, data_d;
    logic         take, get, empty, pause;
    logic         tmr_load;
    logic [MW-1:0] tmr_value;
    dcs_class_e   cls;

    assign empty = ~valid_q | pause;
    assign take  = bus.get_o & ~empty;
    assign get   = ~bus.empty_i & (~valid_q | take);

    always_comb begin
        valid_d = valid_q;
        dc_d    = dc_q;
        data_d  = data_q;
        if (get) begin
            valid_d = 1'b1;
            dc_d    = bus.dc_i;
            data_d  = bus.in;
        end else if (take) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            dc_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            dc_q    <= dc_d;
            data_q  <= data_d;
        end
    end

    // Classify the word as it leaves; take already implies the timer is idle.
    always_comb begin
        cls       = dcs_classify({dc_q, data_q[7:0]});
        tmr_value = '0;
        case (cls)
            CLS_RST: tmr_value = MW'(T_RST);
            CLS_SLP: tmr_value = MW'(T_SLP);
            default: tmr_value = '0;
        endcase
        tmr_load = take & (cls != CLS_NONE) & ~bypass;
    end

    ms_delay #(
        .TICK (TICK),
        .MW   (MW)
    ) u_delay (
        .clk   (clock),
        .rst   (reset),
        .load  (tmr_load),
        .value (tmr_value),
        .clear (bypass),
        .init  (MW'(T_POR)),
        .pause (pause)
    );

    assign bus.get_i   = get;
    assign bus.dc_o    = dc_q;
    assign bus.out     = data_q;
    assign bus.empty_o = empty;
    assign busy        = pause;
endmodule

// File: tb/tb_dcs_pacer.sv
// Directed bench for dcs_pacer at TICK=10: power-on hold, streaming, SWRESET and
// SLPOUT pauses, parameter words, bypass and asynchronous reset mid-pause.
module tb_dcs_pacer;
    localparam int W     = 8;
    localparam int FREQ  = 10_000;
    localparam int T_RST = 5;
    localparam int T_SLP = 12;
    localparam int T_POR = 3;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic bypass = 1'b0;
    logic busy;

    logic [8:0] fifo_q[$];
    logic [8:0] exp_q[$];
    logic       pop_pending = 1'b0;
    int         checks = 0;
    int         errors = 0;

    dcs_pacer_if #(.W(W)) bus();

    dcs_pacer #(
        .W(W), .FREQ(FREQ), .T_RST(T_RST), .T_SLP(T_SLP), .T_POR(T_POR)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .bypass (bypass),
        .bus    (bus),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    // Upstream FIFO model: the pop decision is sampled mid-low phase and the
    // front word is retired just after the edge that consumed it.
    task automatic refresh();
        bus.empty_i = (fifo_q.size() == 0);
        if (fifo_q.size() != 0) begin
            bus.dc_i = fifo_q[0][8];
            bus.in   = fifo_q[0][7:0];
        end else begin
            bus.dc_i = 1'b0;
            bus.in   = '0;
        end
    endtask

    task automatic push(input logic [8:0] w);
        fifo_q.push_back(w);
        refresh();
    endtask

    always @(negedge clock) begin
        #1;
        pop_pending = bus.get_i && !reset;
    end

    always @(posedge clock) begin
        #1;
        if (pop_pending && !reset && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            refresh();
        end
        pop_pending = 1'b0;
    end

    task automatic test_reset();
        push(9'h02A);
        push(9'h101);
        bus.get_o = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.empty_o !== 1'b1 || busy !== 1'b1 || {bus.dc_o, bus.out} !== 9'h000) begin
            errors++;
            $display("FAIL reset_state: empty_o=%b busy=%b word=%h, want 1 1 000", bus.empty_o, busy, {bus.dc_o, bus.out});
        end
        checks++;
        if (bus.get_i !== 1'b1) begin
            errors++;
            $display("FAIL reset_get_i: get_i=%b, want 1", bus.get_i);
        end
        reset = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            checks++;
            if (busy !== (k < 30) || bus.empty_o !== (k < 30)) begin
                errors++;
                $display("FAIL por_hold[%0d]: busy=%b empty_o=%b, want %b", k, busy, bus.empty_o, (k < 30));
            end
            if (k == 5) begin
                #1;
                checks++;
                if (bus.get_i !== 1'b0 || {bus.dc_o, bus.out} !== 9'h02A) begin
                    errors++;
                    $display("FAIL por_held: get_i=%b word=%h, want 0 02a", bus.get_i, {bus.dc_o, bus.out});
                end
            end
        end
        checks++;
        if ({bus.dc_o, bus.out} !== 9'h02A) begin
            errors++;
            $display("FAIL por_word: word=%h, want 02a", {bus.dc_o, bus.out});
        end
    endtask

    task automatic test_stream();
        push(9'h102);
        push(9'h103);
        push(9'h104);
        exp_q = {9'h02A, 9'h101, 9'h102, 9'h103, 9'h104};
        bus.get_o = 1'b1;
        while (exp_q.size() != 0) begin
            logic [8:0] exp_w;
            exp_w = exp_q.pop_front();
            checks++;
            if (bus.empty_o !== 1'b0 || busy !== 1'b0 || {bus.dc_o, bus.out} !== exp_w) begin
                errors++;
                $display("FAIL stream: empty_o=%b busy=%b word=%h, want 0 0 %h", bus.empty_o, busy, {bus.dc_o, bus.out}, exp_w);
            end
            @(negedge clock);
        end
        checks++;
        if (bus.empty_o !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stream_drained: empty_o=%b busy=%b, want 1 0", bus.empty_o, busy);
        end
        bus.get_o = 1'b0;
    endtask

    task automatic test_swreset_slpout();
        push(9'h001);
        push(9'h011);
        @(negedge clock);
        checks++;
        if (bus.empty_o !== 1'b0 || {bus.dc_o, bus.out} !== 9'h001) begin
            errors++;
            $display("FAIL swreset_ready: empty_o=%b word=%h, want 0 001", bus.empty_o, {bus.dc_o, bus.out});
        end
        bus.get_o = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clock);
            checks++;
            if (bus.empty_o !== 1'b1 || busy !== 1'b1 || {bus.dc_o, bus.out} !== 9'h011) begin
                errors++;
                $display("FAIL swreset_pause[%0d]: empty_o=%b busy=%b word=%h, want 1 1 011", k, bus.empty_o, busy, {bus.dc_o, bus.out});
            end
        end
        @(negedge clock);
        checks++;
        if (bus.empty_o !== 1'b0 || busy !== 1'b0 || {bus.dc_o, bus.out} !== 9'h011) begin
            errors++;
            $display("FAIL swreset_end: empty_o=%b busy=%b word=%h, want 0 0 011", bus.empty_o, busy, {bus.dc_o, bus.out});
        end
        for (int k = 1; k <= 120; k++) begin
            @(negedge clock);
            checks++;
            if (bus.empty_o !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL slpout_pause[%0d]: empty_o=%b busy=%b, want 1 1", k, bus.empty_o, busy);
            end
        end
        @(negedge clock);
        checks++;
        if (bus.empty_o !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL slpout_end: empty_o=%b busy=%b, want 1 0", bus.empty_o, busy);
        end
        bus.get_o = 1'b0;
    endtask

    task automatic test_param_no_pause();
        bus.get_o = 1'b1;
        push(9'h110);
        push(9'h02A);
        @(negedge clock);
        checks++;
        if (bus.empty_o !== 1'b0 || {bus.dc_o, bus.out} !== 9'h110) begin
            errors++;
            $display("FAIL param_word: empty_o=%b word=%h, want 0 110", bus.empty_o, {bus.dc_o, bus.out});
        end
        @(negedge clock);
        checks++;
        if (bus.empty_o !== 1'b0 || busy !== 1'b0 || {bus.dc_o, bus.out} !== 9'h02A) begin
            errors++;
            $display("FAIL param_no_pause: empty_o=%b busy=%b word=%h, want 0 0 02a", bus.empty_o, busy, {bus.dc_o, bus.out});
        end
        @(negedge clock);
        checks++;
        if (bus.empty_o !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL param_drained: empty_o=%b busy=%b, want 1 0", bus.empty_o, busy);
        end
        bus.get_o = 1'b0;
    endtask

    task automatic test_bypass();
        push(9'h011);
        push(9'h02A);
        @(negedge clock);
        checks++;
        if ({bus.dc_o, bus.out} !== 9'h011) begin
            errors++;
            $display("FAIL bypass_ready: word=%h, want 011", {bus.dc_o, bus.out});
        end
        bus.get_o = 1'b1;
        @(negedge clock);
        bus.get_o = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clock);
            checks++;
            if (busy !== 1'b1 || bus.empty_o !== 1'b1 || {bus.dc_o, bus.out} !== 9'h02A) begin
                errors++;
                $display("FAIL bypass_pause[%0d]: busy=%b empty_o=%b word=%h, want 1 1 02a", k, busy, bus.empty_o, {bus.dc_o, bus.out});
            end
        end
        bypass = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || bus.empty_o !== 1'b0) begin
            errors++;
            $display("FAIL bypass_mask: busy=%b empty_o=%b, want 0 0", busy, bus.empty_o);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || bus.empty_o !== 1'b0 || {bus.dc_o, bus.out} !== 9'h02A) begin
            errors++;
            $display("FAIL bypass_next: busy=%b empty_o=%b word=%h, want 0 0 02a", busy, bus.empty_o, {bus.dc_o, bus.out});
        end
        bypass = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || bus.empty_o !== 1'b0) begin
            errors++;
            $display("FAIL bypass_release: busy=%b empty_o=%b, want 0 0", busy, bus.empty_o);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || bus.empty_o !== 1'b0) begin
            errors++;
            $display("FAIL bypass_no_resume: busy=%b empty_o=%b, want 0 0", busy, bus.empty_o);
        end
        bus.get_o = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.empty_o !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bypass_drained: empty_o=%b busy=%b, want 1 0", bus.empty_o, busy);
        end
        bus.get_o = 1'b0;
    endtask

    task automatic test_async_reset();
        push(9'h010);
        push(9'h02A);
        @(negedge clock);
        checks++;
        if ({bus.dc_o, bus.out} !== 9'h010) begin
            errors++;
            $display("FAIL slpin_ready: word=%h, want 010", {bus.dc_o, bus.out});
        end
        bus.get_o = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            bus.get_o = 1'b0;
            checks++;
            if (busy !== 1'b1 || bus.empty_o !== 1'b1 || {bus.dc_o, bus.out} !== 9'h02A) begin
                errors++;
                $display("FAIL slpin_pause[%0d]: busy=%b empty_o=%b word=%h, want 1 1 02a", k, busy, bus.empty_o, {bus.dc_o, bus.out});
            end
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.empty_o !== 1'b1 || busy !== 1'b1 || {bus.dc_o, bus.out} !== 9'h000 || bus.get_i !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: empty_o=%b busy=%b word=%h get_i=%b, want 1 1 000 0", bus.empty_o, busy, {bus.dc_o, bus.out}, bus.get_i);
        end
        push(9'h02B);
        #1;
        checks++;
        if (bus.get_i !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_get_i: get_i=%b, want 1", bus.get_i);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            checks++;
            if (busy !== (k < 30) || bus.empty_o !== (k < 30)) begin
                errors++;
                $display("FAIL repor_hold[%0d]: busy=%b empty_o=%b, want %b", k, busy, bus.empty_o, (k < 30));
            end
        end
        checks++;
        if ({bus.dc_o, bus.out} !== 9'h02B) begin
            errors++;
            $display("FAIL repor_word: word=%h, want 02b", {bus.dc_o, bus.out});
        end
    endtask

    initial begin
        bus.get_o = 1'b0;
        refresh();
        test_reset();
        test_stream();
        test_swreset_slpout();
        test_param_no_pause();
        test_bypass();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
